// File: rtl/risc32_pipe_ctrl_pkg.sv
// Shared constants and types for the risc32 pipeline controller:
// stall vector encodings, the ERET exception code and the FSM state type.
package risc32_pipe_ctrl_pkg;

   // Bit order of a stall vector: [0]pc [1]if [2]id [3]ex [4]mem [5]wb, 1 = stop.
   localparam logic [5:0] STALL_MEM  = 6'b011111;
   localparam logic [5:0] STALL_EX   = 6'b001111;
   localparam logic [5:0] STALL_ID   = 6'b000111;
   localparam logic [5:0] STALL_IF   = 6'b000011;
   localparam logic [5:0] STALL_NONE = 6'b000000;

   localparam logic [31:0] EXC_NONE = 32'h0000_0000;
   localparam logic [31:0] EXC_ERET = 32'h0000_000e;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_FLUSH = 1'b1
   } pipe_state_t;

   // ERET returns to the saved EPC; every other exception goes to the vector.
   function automatic logic [31:0] redirect_pc(input logic [31:0] exc,
                                                input logic [31:0] epc,
                                                input logic [31:0] vec);
      return (exc == EXC_ERET) ? epc : vec;
   endfunction

endpackage

// File: rtl/risc32_pipe_ctrl_if.sv
// Signal bundle between the risc32 datapath (master) and the pipeline
// controller (slave).
interface risc32_pipe_ctrl_if;
   import risc32_pipe_ctrl_pkg::*;

   // No valid/ready pairs here: stall requests and excepttype_i are level
   // signals sampled every cycle, and the controller answers in the same cycle.
   logic        stallreq_if_i;
   logic        stallreq_id_i;
   logic        stallreq_ex_i;
   logic        stallreq_mem_i;
   logic [31:0] excepttype_i;
   logic [31:0] cp0_epc_i;
   logic [5:0]  stall_o;
   logic        flush_o;
   logic [31:0] new_pc_o;
   logic        stall_timeout_o;
   logic        busy_o;
   pipe_state_t dbg_state_o;

   modport master (
      output stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i,
      output excepttype_i, cp0_epc_i,
      input  stall_o, flush_o, new_pc_o, stall_timeout_o, busy_o, dbg_state_o
   );

   modport slave (
      input  stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i,
      input  excepttype_i, cp0_epc_i,
      output stall_o, flush_o, new_pc_o, stall_timeout_o, busy_o, dbg_state_o
   );

endinterface

// File: rtl/risc32_pipe_ctrl_stall_prio.sv
// Stall priority encoder: the most downstream requesting stage wins and
// freezes itself plus everything upstream of it.
module risc32_stall_prio
   import risc32_pipe_ctrl_pkg::*;
(
   input  logic       i_req_if,
   input  logic       i_req_id,
   input  logic       i_req_ex,
   input  logic       i_req_mem,
   output logic [5:0] o_stall
);

   always_comb begin
      o_stall = STALL_NONE;
      if (i_req_mem)     o_stall = STALL_MEM;
      else if (i_req_ex) o_stall = STALL_EX;
      else if (i_req_id) o_stall = STALL_ID;
      else if (i_req_if) o_stall = STALL_IF;
   end

endmodule

// File: rtl/risc32_pipe_ctrl.sv
// risc32 pipeline controller: stall priority, exception/ERET flush sequencing
// and stuck-stall watchdog. Optional macro RISC32_PIPE_PERF_EN adds perf counters.
module risc32_pipe_ctrl
   import risc32_pipe_ctrl_pkg::*;
#(
   parameter logic [31:0] EXC_VECTOR    = 32'h0000_0020,
   parameter int unsigned FLUSH_CYCLES  = 1,
   parameter int unsigned STALL_TIMEOUT = 1023
) (
   input  logic                 clk,
   input  logic                 rst,
   risc32_pipe_ctrl_if.slave    pif
`ifdef RISC32_PIPE_PERF_EN
   ,
   output logic [31:0]          stall_cycles_o,
   output logic [31:0]          flush_count_o
`endif
);

   localparam int WD_W = ($clog2(STALL_TIMEOUT + 1) > 10) ? $clog2(STALL_TIMEOUT + 1) : 10;
   localparam logic [WD_W-1:0] WD_LIMIT   = WD_W'(STALL_TIMEOUT);
   localparam logic [WD_W-1:0] WD_MAX     = '1;
   localparam logic [2:0]      FLUSH_LAST = 3'(FLUSH_CYCLES - 1);

   pipe_state_t     r_state;
   logic [2:0]      r_flush_cnt;
   logic [31:0]     r_new_pc;
   logic [WD_W-1:0] r_wd_cnt;
   logic            r_timeout;

   logic [5:0]      w_prio;
   logic            w_run;
   logic            w_exc_take;
   logic            w_stalled;
   logic [31:0]     w_exc_pc;
   logic [WD_W-1:0] w_wd_next;

   risc32_stall_prio u_prio (
      .i_req_if  (pif.stallreq_if_i),
      .i_req_id  (pif.stallreq_id_i),
      .i_req_ex  (pif.stallreq_ex_i),
      .i_req_mem (pif.stallreq_mem_i),
      .o_stall   (w_prio)
   );

   // Same-cycle paths are gated by rst so every output reads idle during reset.
   assign w_run      = rst && (r_state == ST_RUN);
   assign w_exc_take = w_run && (pif.excepttype_i != EXC_NONE);
   assign w_exc_pc   = redirect_pc(pif.excepttype_i, pif.cp0_epc_i, EXC_VECTOR);
   assign w_stalled  = (pif.stall_o != STALL_NONE);
   assign w_wd_next  = (r_wd_cnt == WD_MAX) ? r_wd_cnt : r_wd_cnt + 1'b1;

   assign pif.stall_o         = (w_run && !w_exc_take) ? w_prio : STALL_NONE;
   assign pif.flush_o         = w_exc_take || (r_state == ST_FLUSH);
   assign pif.new_pc_o        = w_exc_take ? w_exc_pc :
                                (r_state == ST_FLUSH) ? r_new_pc : 32'h0;
   assign pif.busy_o          = (r_state != ST_RUN);
   assign pif.stall_timeout_o = r_timeout;
   assign pif.dbg_state_o     = r_state;

   // r_flush_cnt counts flush cycles already completed, including the entry cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= ST_RUN;
         r_flush_cnt <= 3'd0;
         r_new_pc    <= 32'h0;
      end else begin
         case (r_state)
            ST_RUN: begin
               if (w_exc_take) begin
                  r_new_pc <= w_exc_pc;
                  if (FLUSH_CYCLES > 1) begin
                     r_state     <= ST_FLUSH;
                     r_flush_cnt <= 3'd1;
                  end
               end
            end
            ST_FLUSH: begin
               if (r_flush_cnt >= FLUSH_LAST) begin
                  r_state     <= ST_RUN;
                  r_flush_cnt <= 3'd0;
               end else begin
                  r_flush_cnt <= r_flush_cnt + 3'd1;
               end
            end
            default: r_state <= ST_RUN;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wd_cnt  <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_wd_cnt <= w_stalled ? w_wd_next : '0;
         if (w_stalled && (w_wd_next >= WD_LIMIT)) r_timeout <= 1'b1;
      end
   end

`ifdef RISC32_PIPE_PERF_EN
   logic [31:0] r_stall_cycles;
   logic [31:0] r_flush_count;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_stall_cycles <= 32'h0;
         r_flush_count  <= 32'h0;
      end else begin
         if (w_stalled)  r_stall_cycles <= r_stall_cycles + 32'd1;
         if (w_exc_take) r_flush_count  <= r_flush_count + 32'd1;
      end
   end

   assign stall_cycles_o = r_stall_cycles;
   assign flush_count_o  = r_flush_count;
`endif

endmodule

// File: tb/tb_risc32_pipe_ctrl.sv
// Bench for risc32_pipe_ctrl: directed scenarios then random stall/exception
// traffic, all compared against a cycle-level behavioural model.
module tb_risc32_pipe_ctrl;
   import risc32_pipe_ctrl_pkg::*;

   localparam logic [31:0] VEC = 32'h0000_0020;
   localparam int          FC  = 2;
   localparam int          TO  = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   risc32_pipe_ctrl_if pif ();

`ifdef RISC32_PIPE_PERF_EN
   logic [31:0] stall_cycles;
   logic [31:0] flush_count;
`endif

   risc32_pipe_ctrl #(
      .EXC_VECTOR    (VEC),
      .FLUSH_CYCLES  (FC),
      .STALL_TIMEOUT (TO)
   ) dut (
      .clk (clk),
      .rst (rst),
      .pif (pif)
`ifdef RISC32_PIPE_PERF_EN
      ,
      .stall_cycles_o (stall_cycles),
      .flush_count_o  (flush_count)
`endif
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: remaining flush cycles, current stall streak, sticky flag,
   // and a queue holding the redirect target of the flush in progress.
   int          m_flush_left;
   int          m_streak;
   bit          m_timeout;
   logic [31:0] m_stall_cycles;
   logic [31:0] m_flush_count;
   logic [31:0] exp_q[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // Highest requesting stage k (if=0 .. mem=3) stops k+2 stages from the pc up.
   function automatic logic [5:0] stall_ref(input logic [3:0] req);
      for (int k = 3; k >= 0; k--)
         if (req[k]) return 6'((1 << (k + 2)) - 1);
      return 6'd0;
   endfunction

   task automatic model_reset();
      m_flush_left   = 0;
      m_streak       = 0;
      m_timeout      = 0;
      m_stall_cycles = 0;
      m_flush_count  = 0;
      exp_q.delete();
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_stall"}, 32'(pif.stall_o), 32'h0);
      chk({tag, "_flush"}, 32'(pif.flush_o), 32'h0);
      chk({tag, "_newpc"}, pif.new_pc_o, 32'h0);
      chk({tag, "_busy"}, 32'(pif.busy_o), 32'h0);
      chk({tag, "_tmo"}, 32'(pif.stall_timeout_o), 32'h0);
`ifdef RISC32_PIPE_PERF_EN
      chk({tag, "_pstall"}, stall_cycles, 32'h0);
      chk({tag, "_pflush"}, flush_count, 32'h0);
`endif
   endtask

   // req = {mem, ex, id, if}. Drives one cycle, checks at the falling edge.
   task automatic step(input logic [3:0] req, input logic [31:0] exc, input logic [31:0] epc);
      logic [5:0]  e_stall;
      logic [31:0] e_pc;
      bit          e_busy, e_flush, take;
      {pif.stallreq_mem_i, pif.stallreq_ex_i, pif.stallreq_id_i, pif.stallreq_if_i} = req;
      pif.excepttype_i = exc;
      pif.cp0_epc_i    = epc;
      @(negedge clk);
      e_busy  = (m_flush_left > 0);
      take    = !e_busy && (exc != 0);
      e_flush = e_busy || take;
      e_stall = e_flush ? 6'd0 : stall_ref(req);
      if (take) exp_q.push_back((exc == 32'h0000_000e) ? epc : VEC);
      e_pc = e_flush ? exp_q[0] : 32'h0;
      chk("stall", 32'(pif.stall_o), 32'(e_stall));
      chk("flush", 32'(pif.flush_o), 32'(e_flush));
      chk("new_pc", pif.new_pc_o, e_pc);
      chk("busy", 32'(pif.busy_o), 32'(e_busy));
      chk("state", 32'(pif.dbg_state_o), 32'(e_busy));
      chk("timeout", 32'(pif.stall_timeout_o), 32'(m_timeout));
`ifdef RISC32_PIPE_PERF_EN
      chk("perf_stall", stall_cycles, m_stall_cycles);
      chk("perf_flush", flush_count, m_flush_count);
`endif
      if (take) begin
         m_flush_left = FC - 1;
         m_flush_count++;
      end else if (e_busy) begin
         m_flush_left--;
      end
      if (e_flush && m_flush_left == 0) void'(exp_q.pop_front());
      if (e_stall != 0) begin
         m_streak++;
         m_stall_cycles++;
         if (m_streak >= TO) m_timeout = 1;
      end else begin
         m_streak = 0;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [3:0]  r_req;
      logic [31:0] r_exc;
      // Reset with live requests: outputs must still read idle.
      rst = 1'b0;
      pif.stallreq_if_i  = 1'b0;
      pif.stallreq_id_i  = 1'b0;
      pif.stallreq_ex_i  = 1'b0;
      pif.stallreq_mem_i = 1'b1;
      pif.excepttype_i   = 32'h8;
      pif.cp0_epc_i      = 32'h0;
      #12;
      check_reset("reset");
      @(posedge clk);
      #1;
      rst = 1'b1;
      model_reset();

      repeat (3) step(4'b0100, 32'h0, 32'h0);
      step(4'b0000, 32'h0, 32'h0);
      step(4'b1001, 32'h0, 32'h0);
      step(4'b0011, 32'h0, 32'h0);
      step(4'b1000, 32'h8, 32'h0);
      step(4'b1000, 32'h0, 32'h0);
      step(4'b0000, 32'h0, 32'h0);
      step(4'b0000, 32'he, 32'h1234);
      step(4'b0000, 32'h8, 32'h0);
      step(4'b0000, 32'h0, 32'h0);
      repeat (5) step(4'b0010, 32'h0, 32'h0);
      repeat (2) step(4'b0000, 32'h0, 32'h0);

      // Enter FLUSH, then pull reset asynchronously in the middle of it.
      step(4'b0000, 32'h8, 32'h0);
      rst = 1'b0;
      #1;
      check_reset("midflush");
      #2;
      rst = 1'b1;
      model_reset();
      step(4'b0000, 32'h0, 32'h0);

      for (int i = 0; i < 500; i++) begin
         r_req = ($urandom_range(0, 9) < 7) ? 4'($urandom_range(1, 15)) : 4'd0;
         r_exc = 32'h0;
         if ($urandom_range(0, 11) == 0)
            r_exc = $urandom_range(0, 1) ? 32'he : 32'($urandom_range(1, 31));
         step(r_req, r_exc, $urandom);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
